// File: rtl/mvau_wstrm_pkg.sv
// mvau_wstrm_pkg
//   Shared definitions for the MVAU weight streamer: output-buffer depth,
//   the buffered entry layout and the pass-address wrap helper.
package mvau_wstrm_pkg;

    localparam int WSTRM_FIFO_DEPTH = 2;

    // Word width (SIMD*TW) of the default build; the FIFO itself is width-generic
    // and stores entries with exactly this {last, data} layout.
    localparam int WSTRM_DATA_W = 2;

    typedef struct packed {
        logic                    last;
        logic [WSTRM_DATA_W-1:0] data;
    } wstrm_entry_t;

    // Next address in a pass of 'depth' words, wrapping back to 0 after depth-1.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] depth);
        if (addr >= depth - 32'd1) return 32'd0;
        return addr + 32'd1;
    endfunction

endpackage

// File: rtl/mvau_wstrm_fifo2.sv
// mvau_wstrm_fifo2
//   Two-entry registered in-order FIFO used as the streamer's output buffer.
//   Ports:
//     clk, rst  clock, asynchronous active-high reset
//     push, din write din at the end of the cycle
//     pop       retire the head entry at the end of the cycle
//     dout      head entry (registered storage, so no comb path from din)
//     count     number of stored entries, 0..2
module mvau_wstrm_fifo2
    import mvau_wstrm_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [WSTRM_FIFO_DEPTH-1:0][W-1:0] mem_q, mem_d;
    logic                               wr_ptr_q, wr_ptr_d;
    logic                               rd_ptr_q, rd_ptr_d;
    logic [1:0]                         count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // The issue logic upstream bounds occupancy; a push into a full
            // buffer with no pop would mean that bound is broken.
            assert (!(push && !pop && count_q == 2'd2))
                else $error("mvau_wstrm_fifo2: push into full buffer");
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/mvau_weight_streamer.sv
// mvau_weight_streamer
//   Walks the MVAU weight memory sequentially, absorbs its one-cycle registered
//   read latency and presents the words as a valid/ready stream with an
//   end-of-pass marker. One word per cycle under continuous ready.
//   Ports:
//     aclk, areset  clock, asynchronous active-high reset
//     en            run enable; low stops new reads, in-flight/buffered words drain
//     wmem_addr     read address to the weight memory
//     wmem_in       memory data, valid the cycle after the address was sampled
//     wgt_out       head word of the output buffer
//     wgt_valid     wgt_out holds a valid word
//     wgt_last      head word came from address WMEM_DEPTH-1
//     wgt_ready     consumer accepts the head word
//     stall_cnt     (MVAU_WSTRM_STALL_CNT_EN only) saturating count of
//                   cycles with wgt_valid & !wgt_ready
//   Requires 2**WMEM_ADDR_BW >= WMEM_DEPTH.
module mvau_weight_streamer
    import mvau_wstrm_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    en,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_in,
    output logic [SIMD*TW-1:0]      wgt_out,
    output logic                    wgt_valid,
    output logic                    wgt_last,
    input  logic                    wgt_ready
`ifdef MVAU_WSTRM_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam int DW = SIMD * TW;

    logic [WMEM_ADDR_BW-1:0] addr_q, addr_d;
    logic                    inflight_q, inflight_d;
    logic                    last_tag_q, last_tag_d;
    logic [1:0]              count;
    logic [DW:0]             head;
    logic [2:0]              occ;
    logic                    pop, issue;

    assign pop = wgt_valid & wgt_ready;

    // Issue only if the word can still land in the buffer: what is stored plus
    // what is in flight, minus what leaves this cycle, must stay below 2.
    always_comb begin
        occ        = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
        issue      = en & (occ < 3'd2);
        addr_d     = addr_q;
        last_tag_d = last_tag_q;
        inflight_d = issue;
        if (issue) begin
            addr_d     = WMEM_ADDR_BW'(next_addr(32'(addr_q), 32'(WMEM_DEPTH)));
            last_tag_d = (32'(addr_q) == 32'(WMEM_DEPTH - 1));
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q     <= '0;
            inflight_q <= 1'b0;
            last_tag_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            last_tag_q <= last_tag_d;
        end
    end

    // The word issued last cycle is on wmem_in now; its tag travels alongside.
    mvau_wstrm_fifo2 #(.W(DW + 1)) u_buf (
        .clk   (aclk),
        .rst   (areset),
        .push  (inflight_q),
        .pop   (pop),
        .din   ({last_tag_q, wmem_in}),
        .dout  (head),
        .count (count)
    );

    assign wmem_addr = addr_q;
    assign wgt_valid = (count != 2'd0);
    assign wgt_out   = head[DW-1:0];
    assign wgt_last  = head[DW];

`ifdef MVAU_WSTRM_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (wgt_valid && !wgt_ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mvau_weight_streamer.sv
// tb_mvau_weight_streamer
//   Directed/randomized bench for mvau_weight_streamer with SIMD=2, TW=1,
//   WMEM_DEPTH=4 and a registered-read memory holding word[a] = a.
//   Reference model: the stream must be the cyclic sequence 0,1,2,3,... with
//   last on every value 3, and at most 2 words outstanding between issue and pop.
//   Define MVAU_WSTRM_STALL_CNT_EN to also exercise stall_cnt.
module tb_mvau_weight_streamer;

    logic       aclk = 1'b0;
    logic       areset;
    logic       en;
    logic [3:0] wmem_addr;
    logic [1:0] wmem_in;
    logic [1:0] wgt_out;
    logic       wgt_valid;
    logic       wgt_last;
    logic       wgt_ready;
`ifdef MVAU_WSTRM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 aclk = ~aclk;

    mvau_weight_streamer #(
        .SIMD(2), .TW(1), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)
    ) dut (
        .aclk      (aclk),
        .areset    (areset),
        .en        (en),
        .wmem_addr (wmem_addr),
        .wmem_in   (wmem_in),
        .wgt_out   (wgt_out),
        .wgt_valid (wgt_valid),
        .wgt_last  (wgt_last),
        .wgt_ready (wgt_ready)
`ifdef MVAU_WSTRM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Weight memory with one-cycle registered read.
    logic [1:0] mem [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    always @(posedge aclk) wmem_in <= mem[wmem_addr[1:0]];

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         exp_idx = 0;   // index of the next word expected in the stream
    int         n_issue = 0;   // reads seen issued (address advances)
    int         n_pop   = 0;   // words accepted
    logic [3:0] prev_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, score any handshake, then
    // return 1 time unit after the rising edge where inputs may change.
    task automatic cyc();
        @(negedge aclk);
        if (wmem_addr !== prev_addr) n_issue++;
        prev_addr = wmem_addr;
        chk("outstanding_le2", 32'(n_issue - n_pop <= 2), 32'd1);
        if (wgt_valid && wgt_ready) begin
            chk("word", 32'(wgt_out), 32'(exp_idx % 4));
            chk("last", 32'(wgt_last), 32'(exp_idx % 4 == 3));
            exp_idx++;
            n_pop++;
        end
        @(posedge aclk);
        #1;
    endtask

    // Hold reset for two edges, check reset state, then release with en=1,
    // ready=1 so the current cycle is cycle 0.
    task automatic do_reset();
        areset    = 1'b1;
        en        = 1'b0;
        wgt_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("reset_addr",  32'(wmem_addr), 32'd0);
        chk("reset_valid", 32'(wgt_valid), 32'd0);
        chk("reset_last",  32'(wgt_last),  32'd0);
        chk("reset_out",   32'(wgt_out),   32'd0);
        exp_idx   = 0;
        n_issue   = 0;
        n_pop     = 0;
        prev_addr = '0;
        areset    = 1'b0;
        en        = 1'b1;
        wgt_ready = 1'b1;
    endtask

    // First valid word must appear in cycle 2 and be word 0.
    task automatic check_startup();
        chk("start_c0_valid", 32'(wgt_valid), 32'd0);
        cyc();
        chk("start_c1_valid", 32'(wgt_valid), 32'd0);
        cyc();
        chk("start_c2_valid", 32'(wgt_valid), 32'd1);
        chk("start_c2_word",  32'(wgt_out),   32'd0);
    endtask

    initial begin
        int guard;
        int target;

        // Basic stream.
        do_reset();
        check_startup();
        repeat (12) begin
            chk("no_bubble", 32'(wgt_valid), 32'd1);
            cyc();
        end

        // Backpressure while word 1 is at the head.
        guard = 0;
        while (!(wgt_valid && exp_idx % 4 == 1) && guard < 20) begin cyc(); guard++; end
        chk("bp_sync", 32'(guard < 20), 32'd1);
        wgt_ready = 1'b0;
        repeat (5) begin
            chk("bp_valid", 32'(wgt_valid), 32'd1);
            chk("bp_word",  32'(wgt_out),   32'd1);
            chk("bp_last",  32'(wgt_last),  32'd0);
            cyc();
        end
        wgt_ready = 1'b1;
        target = exp_idx + 3;
        guard  = 0;
        while (exp_idx < target && guard < 20) begin cyc(); guard++; end
        chk("bp_resume", 32'(exp_idx >= target), 32'd1);

        // Random ready over 100 words.
        target = exp_idx + 100;
        guard  = 0;
        while (exp_idx < target && guard < 2000) begin
            wgt_ready = 1'($urandom_range(0, 1));
            cyc();
            guard++;
        end
        chk("rand_done", 32'(exp_idx >= target), 32'd1);

        // en low right after word 2 has been issued.
        wgt_ready = 1'b1;
        guard = 0;
        while (wmem_addr !== 4'd3 && guard < 20) begin cyc(); guard++; end
        chk("en_sync", 32'(guard < 20), 32'd1);
        en = 1'b0;
        repeat (3) begin
            chk("en_low_addr_hold", 32'(wmem_addr), 32'd3);
            cyc();
        end
        chk("en_low_drained", 32'(exp_idx % 4), 32'd3);
        chk("en_low_empty",   32'(wgt_valid),   32'd0);
        chk("en_low_addr_end", 32'(wmem_addr),  32'd3);
        en = 1'b1;
        target = exp_idx + 2;
        guard  = 0;
        while (exp_idx < target && guard < 20) begin cyc(); guard++; end
        chk("en_resume", 32'(exp_idx >= target), 32'd1);

        // Asynchronous reset with the buffer full.
        wgt_ready = 1'b0;
        repeat (4) cyc();
        chk("full_valid", 32'(wgt_valid), 32'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("async_valid", 32'(wgt_valid), 32'd0);
        chk("async_addr",  32'(wmem_addr), 32'd0);
        do_reset();
        check_startup();
        repeat (6) cyc();

`ifdef MVAU_WSTRM_STALL_CNT_EN
        do_reset();
        check_startup();
        chk("stall_zero", stall_cnt, 32'd0);
        wgt_ready = 1'b0;
        repeat (7) cyc();
        wgt_ready = 1'b1;
        chk("stall_cnt7", stall_cnt, 32'd7);
        repeat (3) cyc();
        chk("stall_cnt_hold", stall_cnt, 32'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvau_weight_streamer.md
Name: mvau_weight_streamer

Overview:
- Upstream control stage for the MVAU weight memory.
- Generates `wmem_addr` sequentially and absorbs the memory's one-cycle registered read latency.
- Presents weight words, SIMD*TW bits each, as a valid/ready stream to the MVAU compute datapath, with an end-of-pass marker.
- Sustains one word per cycle under continuous ready; drops to zero words under backpressure without losing or duplicating a word.

Parameters:
- SIMD, 2, input lanes per weight word.
- TW, 1, bits per weight.
- WMEM_DEPTH, 4, number of words per pass (memory depth).
- WMEM_ADDR_BW, 4, address width; must satisfy 2^WMEM_ADDR_BW >= WMEM_DEPTH.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- en  in  1  run enable; when low, no new reads are issued.
- wmem_addr  out  WMEM_ADDR_BW  address to the weight memory.
- wmem_in  in  SIMD*TW  weight memory data; valid the cycle after the address was sampled.
- wgt_out  out  SIMD*TW  weight word, head of the output buffer.
- wgt_valid  out  1  wgt_out holds a valid word.
- wgt_last  out  1  word came from address WMEM_DEPTH-1.
- wgt_ready  in  1  consumer accepts the word.

Behaviour:
- Reset (async assert, sync release): wmem_addr=0, wgt_valid=0, wgt_last=0, wgt_out=0, inflight=0, buffer count=0, pass counter=0.
- The memory samples wmem_addr at each aclk edge. A "read issue" in cycle t means the memory captures word[wmem_addr] at the end of t. That word appears on wmem_in during t+1.
- pop = wgt_valid & wgt_ready.
- issue = en & (count + inflight - pop < 2).
- On issue:
  - set inflight=1 and record last_tag = (wmem_addr == WMEM_DEPTH-1);
  - advance wmem_addr by +1, wrapping from WMEM_DEPTH-1 to 0.
- Without issue: inflight=0 and wmem_addr holds.
- While inflight=1: write wmem_in and last_tag into a 2-entry FIFO at the end of the cycle.
  - Simultaneous push and pop is legal; count is unchanged.
- Output buffer is a 2-entry FIFO, registered, in-order.
  - wgt_valid = (count != 0).
  - wgt_out and wgt_last come from the FIFO head.
  - Overflow cannot occur by construction. Any push while count==2 without a pop is an assertion failure.
- Latency: first read issued in cycle 0 after reset release (en=1) gives wgt_valid=1 in cycle 2. Steady state with wgt_ready=1 is one word per cycle with no bubbles.
- Backpressure: while wgt_valid=1 and wgt_ready=0, wgt_out and wgt_last stay stable. Issues stop once count+inflight reaches 2, and no word is lost.
- en low: issues stop immediately. An in-flight word still lands and buffered words still drain. wmem_addr holds, so the pass resumes at the same address.
- Wrap: wgt_last=1 exactly on words from address WMEM_DEPTH-1. The next word comes from address 0.
- WMEM_DEPTH=1: every word has wgt_last=1 and wmem_addr stays 0.
- Reset mid-pass: buffered and in-flight words are discarded. wgt_valid drops asynchronously and the sequence restarts at address 0.

Optional Feature:
- Macro: MVAU_WSTRM_STALL_CNT_EN.
- Defined:
  - adds output port stall_cnt, 32 bits;
  - increments on every cycle with wgt_valid=1 & wgt_ready=0;
  - saturates at all-ones;
  - clears on areset.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mvau_wstrm_pkg holds:
  - localparam WSTRM_FIFO_DEPTH=2;
  - typedef wstrm_entry_t, a packed struct of {logic last; logic [SIMD*TW-1:0] data} (parameterised via its width constant);
  - function next_addr(addr, depth) for the wrap logic.
- Natural sub-module: mvau_wstrm_fifo2, a 2-entry registered FIFO with push, pop, count and async high reset.
- Address and issue logic stay in the top module.

Test Plan:
- Common setup: SIMD=2, TW=1, WMEM_DEPTH=4; memory model with registered read holding 0,1,2,3.
- Basic stream: reset release, en=1, wgt_ready=1.
  - Expected: wgt_valid first rises in cycle 2.
  - Expected: wgt_out sequence 0,1,2,3,0,1,... with no bubbles.
  - Expected: wgt_last=1 only on value 3.
- Backpressure: wgt_ready=0 for 5 cycles mid-pass, holding word 1.
  - Expected: wgt_out=1 stable throughout, and no more than 2 issues outstanding.
  - Expected: after release, the sequence continues 1,2,3 with no loss or duplicate.
- Random wgt_ready (50%) over 100 words.
  - Expected: the output equals the reference cyclic sequence 0,1,2,3 repeated.
  - Expected: wgt_last on every 4th word.
- en low for 3 cycles after word 2 is issued.
  - Expected: word 2 still appears and wmem_addr holds at 3.
  - Expected: after en returns high, the next words are 3,0.
- areset pulse mid-pass with the buffer full.
  - Expected: wgt_valid=0 asynchronously and wmem_addr=0.
  - Expected: after release, the first word is 0 in cycle 2.
- With MVAU_WSTRM_STALL_CNT_EN defined: wgt_ready=0 for 7 cycles while valid.
  - Expected: stall_cnt=7 and stays 7 after ready returns.
